seq_mul_controller: RTL and testbench

Control FSM for the shift-add sequential multiplier. Accepts a start handshake, then sequences the accumulator adder, the operand mux and the shift registers for WIDTH_M iterations (test LSB, optionally add, shift). Holds a done indication until the consumer acknowledges. Holds no operand data: it consumes only the multiplier LSB and drives per-cycle enables into the existing datapath.

---
 rtl/seq_mul_controller.sv | 113 +++++++++++
 tb/tb_seq_mul_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_controller.sv
// Control FSM for a shift-add sequential multiplier: sequences load, test, optional add
// and shift for WIDTH_M iterations, then holds done until the consumer acknowledges.
module seq_mul_controller #(
    parameter int WIDTH_M = 16,
    localparam int CW = $clog2(WIDTH_M + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic          q_lsb,
    input  logic          abort,
    input  logic          result_ack,
    output logic          load,
    output logic          clear_acc,
    output logic          mux_sel,
    output logic          add_signal,
    output logic          shift,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] bit_count,
    output logic [2:0]    dbg_state
);

    // Handshake: a multiply is accepted on the rising edge where start_valid and
    // start_ready are both high; the product is released on the edge where
    // result_ack is high while done is asserted.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH_M - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_bit_count;
    logic [CW-1:0] w_bit_count_next;
    logic          w_active;

    assign w_active = (r_state == S_LOAD) || (r_state == S_TEST) ||
                      (r_state == S_ADD)  || (r_state == S_SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_count <= '0;
        end else begin
            r_state     <= w_next_state;
            r_bit_count <= w_bit_count_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        start_ready  = 1'b0;
        load         = 1'b0;
        clear_acc    = 1'b0;
        mux_sel      = 1'b0;
        add_signal   = 1'b0;
        shift        = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                load         = 1'b1;
                clear_acc    = 1'b1;
                w_next_state = S_TEST;
            end
            S_TEST: begin
                w_next_state = q_lsb ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                mux_sel      = 1'b1;
                add_signal   = 1'b1;
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                shift        = 1'b1;
                w_next_state = (r_bit_count == LAST_BIT) ? S_DONE : S_TEST;
            end
            S_DONE: begin
                done = 1'b1;
                if (result_ack) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        // Abort overrides the sequencing choice but not the current Moore outputs.
        if (abort && w_active) w_next_state = S_IDLE;
    end

    always_comb begin
        w_bit_count_next = r_bit_count;
        if (abort && w_active)
            w_bit_count_next = '0;
        else if (r_state == S_LOAD)
            w_bit_count_next = '0;
        else if (r_state == S_SHIFT)
            w_bit_count_next = r_bit_count + CW'(1);
    end

    assign busy      = (r_state != S_IDLE);
    assign bit_count = r_bit_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_mul_controller.sv
// Directed bench for seq_mul_controller: two instances (WIDTH_M=4 and 16), each with a
// behavioural shift-add datapath so products and cycle counts can be checked end to end.
module tb_seq_mul_controller;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // WIDTH_M = 4 instance and datapath
    logic       sv4, st4, qlsb4, ab4, ack4, ld4, clr4, mux4, add4, sh4, busy4, done4;
    logic [2:0] bc4, dbg4;
    logic [3:0] mcand4, mplier4, a4, q4, m4;
    logic       c4;
    int         adds4 = 0, shifts4 = 0;

    seq_mul_controller #(.WIDTH_M(4)) u_dut4 (
        .clk(clk), .reset(reset), .start_valid(sv4), .start_ready(st4), .q_lsb(qlsb4),
        .abort(ab4), .result_ack(ack4), .load(ld4), .clear_acc(clr4), .mux_sel(mux4),
        .add_signal(add4), .shift(sh4), .busy(busy4), .done(done4), .bit_count(bc4),
        .dbg_state(dbg4)
    );

    always @(posedge clk) begin
        if (ld4) begin m4 <= mcand4; q4 <= mplier4; end
        if (clr4) begin a4 <= '0; c4 <= 1'b0; end
        if (add4) {c4, a4} <= {1'b0, a4} + {1'b0, (mux4 ? m4 : 4'd0)};
        if (sh4) {c4, a4, q4} <= {1'b0, c4, a4, q4[3:1]};
        if (add4) adds4 <= adds4 + 1;
        if (sh4) shifts4 <= shifts4 + 1;
    end
    assign qlsb4 = q4[0];

    // WIDTH_M = 16 instance and datapath
    logic        sv16, st16, qlsb16, ab16, ack16, ld16, clr16, mux16, add16, sh16, busy16, done16;
    logic [4:0]  bc16;
    logic [2:0]  dbg16;
    logic [15:0] mcand16, mplier16, a16, q16, m16;
    logic        c16;
    int          adds16 = 0, shifts16 = 0;

    seq_mul_controller #(.WIDTH_M(16)) u_dut16 (
        .clk(clk), .reset(reset), .start_valid(sv16), .start_ready(st16), .q_lsb(qlsb16),
        .abort(ab16), .result_ack(ack16), .load(ld16), .clear_acc(clr16), .mux_sel(mux16),
        .add_signal(add16), .shift(sh16), .busy(busy16), .done(done16), .bit_count(bc16),
        .dbg_state(dbg16)
    );

    always @(posedge clk) begin
        if (ld16) begin m16 <= mcand16; q16 <= mplier16; end
        if (clr16) begin a16 <= '0; c16 <= 1'b0; end
        if (add16) {c16, a16} <= {1'b0, a16} + {1'b0, (mux16 ? m16 : 16'd0)};
        if (sh16) {c16, a16, q16} <= {1'b0, c16, a16, q16[15:1]};
        if (add16) adds16 <= adds16 + 1;
        if (sh16) shifts16 <= shifts16 + 1;
    end
    assign qlsb16 = q16[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done4(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done4 && cyc < 200);
        check("done4_seen", {31'd0, done4}, 32'd1);
    endtask

    task automatic wait_done16(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done16 && cyc < 400);
        check("done16_seen", {31'd0, done16}, 32'd1);
    endtask

    // Entered and left at a falling edge; cycle 1 is the LOAD cycle after the accept edge.
    task automatic run4(input logic [3:0] mc, input logic [3:0] mp, input int exp_cyc,
                        input int exp_adds, input logic [7:0] exp_prod, input bit do_ack);
        int a0, s0, cyc;
        mcand4  = mc;
        mplier4 = mp;
        check("ready4_before_start", {31'd0, st4}, 32'd1);
        a0  = adds4;
        s0  = shifts4;
        sv4 = 1'b1;
        @(posedge clk);
        #1 sv4 = 1'b0;
        wait_done4(cyc);
        check("cycles4", cyc, exp_cyc);
        check("product4", {24'd0, a4, q4}, {24'd0, exp_prod});
        check("adds4", adds4 - a0, exp_adds);
        check("shifts4", shifts4 - s0, 32'd4);
        check("bit_count4_done", {29'd0, bc4}, 32'd4);
        if (do_ack) begin
            ack4 = 1'b1;
            @(posedge clk);
            #1 ack4 = 1'b0;
            @(negedge clk);
            check("ready4_after_ack", {31'd0, st4}, 32'd1);
            check("done4_after_ack", {31'd0, done4}, 32'd0);
        end
    endtask

    task automatic run16(input logic [15:0] mc, input logic [15:0] mp, input int exp_cyc,
                         input int exp_adds, input logic [31:0] exp_prod);
        int a0, s0, cyc;
        mcand16  = mc;
        mplier16 = mp;
        check("ready16_before_start", {31'd0, st16}, 32'd1);
        a0   = adds16;
        s0   = shifts16;
        sv16 = 1'b1;
        @(posedge clk);
        #1 sv16 = 1'b0;
        wait_done16(cyc);
        check("cycles16", cyc, exp_cyc);
        check("product16", {a16, q16}, exp_prod);
        check("adds16", adds16 - a0, exp_adds);
        check("shifts16", shifts16 - s0, 32'd16);
        check("bit_count16_done", {27'd0, bc16}, 32'd16);
        ack16 = 1'b1;
        @(posedge clk);
        #1 ack16 = 1'b0;
        @(negedge clk);
        check("ready16_after_ack", {31'd0, st16}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, cyc;
        bit  seen, ok;
        reset = 1'b1;
        {sv4, ab4, ack4, sv16, ab16, ack16} = '0;
        mcand4 = '0; mplier4 = '0; mcand16 = '0; mplier16 = '0;
        #1;
        check("rst_ready4", {31'd0, st4}, 32'd1);
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        check("rst_bitcount4", {29'd0, bc4}, 32'd0);
        check("rst_ready16", {31'd0, st16}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 6 * 11 = 66, three add pulses, done at cycle 13
        run4(4'b0110, 4'b1011, 13, 3, 8'h42, 1'b1);

        // WIDTH_M = 16 extremes
        run16(16'h1234, 16'h0000, 34, 0, 32'h0000_0000);
        run16(16'hFFFF, 16'hFFFF, 50, 16, 32'hFFFE_0001);

        // Abort during the third SHIFT
        mcand4 = 4'b0110; mplier4 = 4'b1011;
        sv4 = 1'b1;
        @(posedge clk);
        #1 sv4 = 1'b0;
        n = 0; cyc = 0;
        while (n < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (sh4) n++;
        end
        check("abort_state_shift", {29'd0, dbg4}, 32'd4);
        ab4 = 1'b1;
        @(posedge clk);
        #1 ab4 = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'd0, st4}, 32'd1);
        check("abort_busy", {31'd0, busy4}, 32'd0);
        check("abort_bitcount", {29'd0, bc4}, 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done4) seen = 1'b1;
        end
        check("no_done_after_abort", {31'd0, seen}, 32'd0);
        run4(4'b1111, 4'b0101, 12, 2, 8'h4B, 1'b1);

        // Hold in DONE with start_valid and abort asserted, then ack + held start
        run4(4'b1001, 4'b0011, 12, 2, 8'h1B, 1'b0);
        sv4 = 1'b1;
        ab4 = 1'b1;
        ok  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!done4 || st4 || ld4) ok = 1'b0;
        end
        check("done_held", {31'd0, ok}, 32'd1);
        ack4 = 1'b1;
        @(posedge clk);
        #1 ack4 = 1'b0;
        ab4 = 1'b0;
        @(negedge clk);
        check("ack_abort_idle", {29'd0, dbg4}, 32'd0);
        @(negedge clk);
        check("load_two_after_ack", {31'd0, ld4}, 32'd1);
        sv4 = 1'b0;
        wait_done4(cyc);
        check("cycles4_after_load", cyc, 32'd11);
        check("product4_rerun", {24'd0, a4, q4}, 32'h1B);
        ack4 = 1'b1;
        @(posedge clk);
        #1 ack4 = 1'b0;
        @(negedge clk);

        // Asynchronous reset while in ADD
        mcand4 = 4'b0110; mplier4 = 4'b1011;
        sv4 = 1'b1;
        @(posedge clk);
        #1 sv4 = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!add4 && cyc < 20);
        check("in_add_state", {29'd0, dbg4}, 32'd3);
        #2 reset = 1'b1;
        #1;
        check("arst_ready", {31'd0, st4}, 32'd1);
        check("arst_busy", {31'd0, busy4}, 32'd0);
        check("arst_add", {31'd0, add4}, 32'd0);
        check("arst_shift_load_done", {29'd0, sh4, ld4, done4}, 32'd0);
        check("arst_bitcount", {29'd0, bc4}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run4(4'b0110, 4'b1011, 13, 3, 8'h42, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
